rr_arbiter_n: RTL and testbench
===============================

Name: rr_arbiter_n

Overview:
Round-robin arbiter that shares one resource between WIDTH requesters. It uses the same WIDTH convention and ceil-log2 index encoding as the team's priority/count blocks. The arbiter grants one requester at a time and holds the grant until that requester drops its request or a hold timeout expires, then rotates priority. It sits in front of any single-ported datapath resource, and downstream steering muxes are driven from gnt_idx.

Parameters:
- WIDTH, 7, number of requesters (>=2).
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; 0 disables the timeout.
- IDX_W, clog2(WIDTH) (derived localparam, minimum 1), width of the encoded grant index.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  WIDTH  per-requester request level; held high while the resource is wanted.
- gnt  out  WIDTH  one-hot grant, registered; all zero when no owner.
- gnt_idx  out  IDX_W  binary index of the current owner; 0 when gnt_valid=0.
- gnt_valid  out  1  high while any grant is active (equals OR of gnt).
- timeout  out  1  one-cycle pulse on the cycle the grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async, rst_n=0): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0. This takes effect immediately, including mid-grant. Operation resumes on the first rising edge after rst_n rises.
- State machine has two states, IDLE and OWN.
- IDLE, req==0: stay in IDLE, outputs stay 0.
- IDLE, req!=0: winner = first set bit of req searching upward from ptr, wrapping WIDTH-1 to 0.
  - Next edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=OWN.
  - Latency from req sampled to gnt visible is 1 cycle.
- OWN: hold_cnt increments by 1 per cycle, saturating. Release is checked in this priority order:
  1. req[owner]==0: next edge gnt=0, gnt_valid=0, gnt_idx=0, state=IDLE, ptr=(owner+1) mod WIDTH. No timeout pulse.
  2. Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: same release, plus timeout=1 for exactly that one cycle. The owner therefore holds for exactly MAX_HOLD cycles.
  3. Else: grant unchanged. Requests from other requesters are ignored while in OWN.
- There is always at least one IDLE cycle between consecutive grants. Re-arbitration happens in that IDLE cycle using the updated ptr.
- ptr wraps from WIDTH-1 to 0. When WIDTH is not a power of two, ptr values >= WIDTH are unreachable and must never be produced.
- A requester that was force-released may win again only when its turn comes round again in rotation. If it is the only requester, it is re-granted after the one IDLE cycle.
- req bits that are X/Z are treated as a bench error. RTL is not required to handle them; assertions flag X on req while rst_n=1.
- Simultaneous owner-drop and timeout on the same cycle: the drop takes priority and timeout stays 0.
- gnt must always be one-hot or zero. gnt_idx must equal the encoded gnt.

Decomposition:
- Shared package arb_pkg contains:
  - the clog2 function (the same ceil-log2 used for index widths across the codebase);
  - the state enum {IDLE, OWN};
  - the derived IDX_W rule.
- One combinational sub-module, rr_pick_n (WIDTH), takes req and ptr and produces winner index plus any_req. It does the rotate-then-find-first lookup.
- rr_arbiter_n holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Async reset mid-grant: owner=3 with gnt=0001000; drop rst_n between edges -> gnt=0, gnt_idx=0, gnt_valid=0 immediately. After release with req=0, all outputs stay 0.
- Basic rotation (WIDTH=7, MAX_HOLD=0): req=0000101 after reset -> gnt=0000001, idx 0. Clear req[0] -> gnt=0 for one cycle, then gnt=0000100, idx 2.
- Wrap-around: hold req=1000001, releasing each owner after 2 cycles. Grants go idx 0, 6, 0, 6. After owner 6 releases, ptr=0.
- Timeout (MAX_HOLD=4): req=1111111 held constant. Each owner holds gnt for exactly 4 cycles, timeout pulses on the 4th, 1 idle cycle follows. Owner sequence is 0,1,2,3,4,5,6,0.
- Drop-vs-timeout tie (MAX_HOLD=4): owner drops req on its 4th grant cycle -> release with timeout=0.
- Lone requester timeout: only req[2]=1, MAX_HOLD=4 -> pattern 4 cycles granted, 1 idle, repeating. timeout pulses every 5 cycles; gnt_idx=2 throughout each grant.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbitration helpers: ceil-log2 index sizing and the arbiter state encoding.
package arb_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

  // Index ports are never narrower than one bit, even for degenerate widths.
  function automatic int unsigned idx_w(input int unsigned width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick_n.sv
// Rotating first-set finder: returns the first requester at or above ptr, wrapping at WIDTH-1.
module rr_pick_n
  import arb_pkg::*;
#(
  parameter  int unsigned WIDTH = 7,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic        found;
  int unsigned pos;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pos = int'(ptr) + i;
      if (pos >= WIDTH) pos = pos - WIDTH;
      // Shift-and-mask keeps the bit select free of index-width mismatches.
      if (!found && ((req & (WIDTH'(1) << pos)) != '0)) begin
        found  = 1'b1;
        winner = IDX_W'(pos);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter with grant hold until request drop or MAX_HOLD-cycle timeout.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter  int unsigned WIDTH    = 7,
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned IDX_W    = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int unsigned CNT_W     = (MAX_HOLD < 2) ? 1 : clog2(MAX_HOLD);
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] pick_idx;
  logic             any_req;
  logic             owner_req;
  logic             release_c;
  logic             timeout_c;

  rr_pick_n #(
    .WIDTH (WIDTH)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_idx),
    .any_req (any_req)
  );

  // gnt_q is one-hot on the owner, so masking req with it yields req[owner].
  assign owner_req = |(req & gnt_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    release_c  = 1'b0;
    timeout_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = OWN;
          gnt_d      = WIDTH'(1) << pick_idx;
          gnt_idx_d  = pick_idx;
          hold_cnt_d = '0;
        end
      end
      OWN: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        // A dropped request wins over a coincident timeout, so no pulse then.
        if (!owner_req) begin
          release_c = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(HOLD_LAST))) begin
          release_c = 1'b1;
          timeout_c = 1'b1;
        end
        if (release_c) begin
          state_d    = IDLE;
          gnt_d      = '0;
          gnt_idx_d  = '0;
          hold_cnt_d = '0;
          ptr_d      = (gnt_idx_q == IDX_W'(WIDTH - 1)) ? '0 : gnt_idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_c;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: one instance without timeout, one with MAX_HOLD=4.
module tb_rr_arbiter_n;

  typedef struct packed {
    logic       rst;
    logic [6:0] req;
    logic [6:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] req0, req4, gnt0, gnt4;
  logic [2:0] idx0, idx4;
  logic       v0, v4, to0, to4;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  rr_arbiter_n #(.WIDTH(7), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0),
    .gnt_idx(idx0), .gnt_valid(v0), .timeout(to0)
  );

  rr_arbiter_n #(.WIDTH(7), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4),
    .gnt_idx(idx4), .gnt_valid(v4), .timeout(to4)
  );

  always @(posedge clk) begin
    if (rst_n) assert (!$isunknown(req0) && !$isunknown(req4));
  end

  function automatic vec_t mk(input logic rst, input logic [6:0] r, input logic [6:0] g,
                              input logic [2:0] i, input logic v, input logic t);
    vec_t x;
    x = {rst, r, g, i, v, t};
    return x;
  endfunction

  task automatic check(input string name, input logic sel, input logic [6:0] eg,
                       input logic [2:0] ei, input logic ev, input logic et);
    logic [11:0] got, exp;
    got = sel ? {gnt4, idx4, v4, to4} : {gnt0, idx0, v0, to0};
    exp = {eg, ei, ev, et};
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
               name, got[11:5], got[4:2], got[1], got[0], eg, ei, ev, et);
    end
  endtask

  // Drive req just after an edge, check this cycle's outputs, then advance one edge.
  task automatic cyc(input string name, input logic sel, input logic [6:0] r,
                     input logic [6:0] eg, input logic [2:0] ei, input logic ev, input logic et);
    if (sel) req4 = r;
    else     req0 = r;
    #1;
    check(name, sel, eg, ei, ev, et);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = '0;
    req4  = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] g;
    // basic rotation, MAX_HOLD=0
    tbl.push_back(mk(1, 7'b0000101, 7'b0000000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 7'b0000100, 7'b0000001, 3'd0, 1, 0));
    tbl.push_back(mk(0, 7'b0000100, 7'b0000000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 7'b0000100, 7'b0000100, 3'd2, 1, 0));
    tbl.push_back(mk(0, 7'b0000000, 7'b0000100, 3'd2, 1, 0));
    tbl.push_back(mk(0, 7'b0000000, 7'b0000000, 3'd0, 0, 0));
    // wrap-around between requesters 0 and 6
    tbl.push_back(mk(1, 7'b1000001, 7'b0000000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 7'b1000001, 7'b0000001, 3'd0, 1, 0));
    tbl.push_back(mk(0, 7'b1000000, 7'b0000001, 3'd0, 1, 0));
    tbl.push_back(mk(0, 7'b1000001, 7'b0000000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 7'b1000001, 7'b1000000, 3'd6, 1, 0));
    tbl.push_back(mk(0, 7'b0000001, 7'b1000000, 3'd6, 1, 0));
    tbl.push_back(mk(0, 7'b1000001, 7'b0000000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 7'b1000001, 7'b0000001, 3'd0, 1, 0));
    tbl.push_back(mk(0, 7'b1000000, 7'b0000001, 3'd0, 1, 0));
    tbl.push_back(mk(0, 7'b1000001, 7'b0000000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 7'b1000001, 7'b1000000, 3'd6, 1, 0));
    tbl.push_back(mk(0, 7'b0000001, 7'b1000000, 3'd6, 1, 0));
    tbl.push_back(mk(0, 7'b0000000, 7'b0000000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 7'b1111111, 7'b0000000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 7'b0000000, 7'b0000001, 3'd0, 1, 0));
    tbl.push_back(mk(0, 7'b0000000, 7'b0000000, 3'd0, 0, 0));

    rst_n = 1'b1;
    req0  = '0;
    req4  = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_dut0", 0, 7'b0, 3'd0, 0, 0);
    check("reset_dut4", 1, 7'b0, 3'd0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      cyc($sformatf("vec%0d", i), 0, tbl[i].req, tbl[i].gnt, tbl[i].idx, tbl[i].valid, tbl[i].to);
    end

    // all requesting, MAX_HOLD=4: 4 grant cycles, timeout on the 4th, one idle cycle
    do_reset();
    cyc("to_idle_start", 1, 7'h7F, 7'b0, 3'd0, 0, 0);
    for (int o = 0; o < 8; o++) begin
      g = 7'b0000001 << (o % 7);
      for (int k = 0; k < 4; k++)
        cyc($sformatf("to_own%0d_c%0d", o, k), 1, 7'h7F, g, 3'(o % 7), 1, k == 3);
      cyc($sformatf("to_gap%0d", o), 1, 7'h7F, 7'b0, 3'd0, 0, 0);
    end

    // owner drops on its 4th cycle: release without timeout, ptr moves to 4
    do_reset();
    cyc("tie_idle", 1, 7'b0001000, 7'b0, 3'd0, 0, 0);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("tie_own_c%0d", k), 1, 7'b0001000, 7'b0001000, 3'd3, 1, 0);
    cyc("tie_drop_4th", 1, 7'b0000000, 7'b0001000, 3'd3, 1, 0);
    cyc("tie_released", 1, 7'b0000000, 7'b0, 3'd0, 0, 0);
    cyc("tie_rearb", 1, 7'b1111111, 7'b0, 3'd0, 0, 0);
    cyc("tie_next_owner", 1, 7'b1111111, 7'b0010000, 3'd4, 1, 0);

    // lone requester 2 repeatedly timed out and re-granted
    do_reset();
    cyc("lone_idle", 1, 7'b0000100, 7'b0, 3'd0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++)
        cyc($sformatf("lone_p%0d_c%0d", p, k), 1, 7'b0000100, 7'b0000100, 3'd2, 1, k == 3);
      cyc($sformatf("lone_gap%0d", p), 1, 7'b0000100, 7'b0, 3'd0, 0, 0);
    end

    // async reset in the middle of a grant to requester 3
    do_reset();
    cyc("ar_idle", 0, 7'b0001000, 7'b0, 3'd0, 0, 0);
    cyc("ar_own", 0, 7'b0001000, 7'b0001000, 3'd3, 1, 0);
    check("ar_pre", 0, 7'b0001000, 3'd3, 1, 0);
    #2 rst_n = 1'b0;
    req0 = '0;
    #1;
    check("ar_immediate", 0, 7'b0, 3'd0, 0, 0);
    @(posedge clk);
    #1;
    check("ar_held", 0, 7'b0, 3'd0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      cyc($sformatf("ar_after%0d", k), 0, 7'b0, 7'b0, 3'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
